// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and default bus widths,
// used by both this requester and the APB completer RAM.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns one command into one SETUP/ACCESS transfer and
// returns a single-cycle response, aborting after TIMEOUT wait cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Wait count seen during the TIMEOUT-th ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a late completion beats the abort.
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wait_cnt_q == CNT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                paddr_d   = '0;
                pwdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Gated by presetn so the block never advertises readiness while in reset.
    assign cmd_ready = presetn && (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a configurable completer model plus a
// negedge monitor that counts bus cycles, acceptances and responses.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          cfg_wait   = 0;
    logic [31:0] cfg_prdata = '0;
    logic        cfg_slverr = 1'b0;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    assign prdata  = cfg_prdata;
    assign pslverr = cfg_slverr;

    // Completer: holds pready low for cfg_wait ACCESS cycles, then raises it.
    int acc_n = 0;
    initial pready = 1'b0;
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready <= (acc_n >= cfg_wait);
            acc_n  <= acc_n + 1;
        end else begin
            pready <= 1'b0;
            acc_n  <= 0;
        end
    end

    // Monitor: cumulative counters; tests work on deltas.
    int          cyc = 0;
    int          psel_cyc = 0, penable_cyc = 0, rsp_cnt = 0, acc_cnt = 0;
    int          last_acc = 0, last_rsp = 0, last_gap = 0, bad_paddr = 0;
    logic        prev_psel = 1'b0;
    logic [31:0] prev_paddr = '0;
    always @(negedge pclk) begin
        cyc <= cyc + 1;
        if (psel)      psel_cyc    <= psel_cyc + 1;
        if (penable)   penable_cyc <= penable_cyc + 1;
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            last_rsp <= cyc;
        end
        if (cmd_valid && cmd_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_gap <= cyc - last_acc;
            last_acc <= cyc;
        end
        if (psel && prev_psel && paddr != prev_paddr) bad_paddr <= bad_paddr + 1;
        prev_psel  <= psel;
        prev_paddr <= paddr;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one command and wait (bounded) for its response.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int a0;
        int r0;
        bool_loop: begin end
        a0 = acc_cnt;
        r0 = rsp_cnt;
        @(posedge pclk); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
            @(posedge pclk); #1;
        end
        cmd_valid = 1'b0;
        check_eq("accept_seen", 64'(acc_cnt - a0), 64'd1);
        for (int i = 0; i < 40 && rsp_cnt == r0; i++) begin
            @(posedge pclk); #1;
        end
        check_eq("rsp_seen", 64'(rsp_cnt - r0), 64'd1);
        @(posedge pclk); #1;
    endtask

    int p0, e0, b0, r0, a0;

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        check_eq("rst_psel", 64'(psel), 64'd0);
        check_eq("rst_penable", 64'(penable), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_paddr", 64'(paddr), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        presetn = 1'b1;
        @(negedge pclk);
        check_eq("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write, zero wait states
        cfg_wait = 0; cfg_prdata = 32'h0BAD_F00D; cfg_slverr = 1'b0;
        p0 = psel_cyc; e0 = penable_cyc; b0 = bad_paddr;
        run_cmd(1'b1, 32'h05, 32'hDEAD_BEEF);
        check_eq("wr_psel_cyc", 64'(psel_cyc - p0), 64'd2);
        check_eq("wr_penable_cyc", 64'(penable_cyc - e0), 64'd1);
        check_eq("wr_latency", 64'(last_rsp - last_acc), 64'd3);
        check_eq("wr_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("wr_pwrite_hold", 64'(pwrite), 64'd1);
        check_eq("wr_paddr_hold", 64'(paddr), 64'h05);
        check_eq("wr_pwdata_hold", 64'(pwdata), 64'hDEAD_BEEF);
        check_eq("wr_rsp_valid_low", 64'(rsp_valid), 64'd0);

        // Read, three wait states
        cfg_wait = 3; cfg_prdata = 32'hDEAD_BEEF; cfg_slverr = 1'b0;
        p0 = psel_cyc; e0 = penable_cyc; b0 = bad_paddr;
        run_cmd(1'b0, 32'h05, 32'h0);
        check_eq("rd_psel_cyc", 64'(psel_cyc - p0), 64'd5);
        check_eq("rd_penable_cyc", 64'(penable_cyc - e0), 64'd4);
        check_eq("rd_paddr_stable", 64'(bad_paddr - b0), 64'd0);
        check_eq("rd_latency", 64'(last_rsp - last_acc), 64'd6);
        check_eq("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        check_eq("rd_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("rd_pwrite", 64'(pwrite), 64'd0);

        // Read with slave error
        cfg_wait = 0; cfg_prdata = 32'h1234_5678; cfg_slverr = 1'b1;
        run_cmd(1'b0, 32'h28, 32'h0);
        check_eq("err_rsp_err", 64'(rsp_err), 64'd1);
        check_eq("err_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
        check_eq("err_paddr", 64'(paddr), 64'h28);

        // Timeout: pready never rises
        cfg_wait = 255; cfg_prdata = 32'hCAFE_0001; cfg_slverr = 1'b0;
        e0 = penable_cyc;
        run_cmd(1'b0, 32'h10, 32'h0);
        check_eq("to_penable_cyc", 64'(penable_cyc - e0), 64'd16);
        check_eq("to_latency", 64'(last_rsp - last_acc), 64'd18);
        check_eq("to_rsp_err", 64'(rsp_err), 64'd1);
        check_eq("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        repeat (3) @(posedge pclk);
        #1;
        check_eq("to_rsp_err_hold", 64'(rsp_err), 64'd1);

        // pready in the 16th ACCESS cycle completes normally
        cfg_wait = 15; cfg_prdata = 32'hCAFE_0002; cfg_slverr = 1'b0;
        e0 = penable_cyc;
        run_cmd(1'b0, 32'h14, 32'h0);
        check_eq("late_penable_cyc", 64'(penable_cyc - e0), 64'd16);
        check_eq("late_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("late_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0002);

        // Reset in the middle of ACCESS
        cfg_wait = 255;
        r0 = rsp_cnt; a0 = acc_cnt;
        @(posedge pclk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
            @(posedge pclk); #1;
        end
        cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #2;
        check_eq("mid_penable_before", 64'(penable), 64'd1);
        presetn = 1'b0;
        #1;
        check_eq("mid_rst_psel", 64'(psel), 64'd0);
        check_eq("mid_rst_penable", 64'(penable), 64'd0);
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        @(negedge pclk);
        check_eq("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_rel_paddr", 64'(paddr), 64'd0);
        repeat (4) @(posedge pclk);
        #1;
        check_eq("mid_no_rsp", 64'(rsp_cnt - r0), 64'd0);

        // cmd_valid held high across three commands
        cfg_wait = 0; cfg_prdata = 32'h0; cfg_slverr = 1'b0;
        a0 = acc_cnt; r0 = rsp_cnt; p0 = psel_cyc;
        @(posedge pclk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h1;
        for (int i = 0; i < 40 && (acc_cnt - a0) < 3; i++) begin
            @(posedge pclk); #1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && (rsp_cnt - r0) < 3; i++) begin
            @(posedge pclk); #1;
        end
        repeat (2) @(posedge pclk);
        #1;
        check_eq("b2b_accepts", 64'(acc_cnt - a0), 64'd3);
        check_eq("b2b_responses", 64'(rsp_cnt - r0), 64'd3);
        check_eq("b2b_psel_cyc", 64'(psel_cyc - p0), 64'd6);
        check_eq("b2b_spacing", 64'(last_gap), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
